dataframe_merger: RTL



---
 rtl/dataframe_merger.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dataframe_merger.sv
// Frame-level round-robin merger of CHANNEL_NUM AXI-Stream inputs into one stream.
// A granted channel owns the output until its TLAST beat is accepted; one output register stage.
module dataframe_merger #(
  parameter int CHANNEL_NUM    = 8,
  parameter int TDATA_WIDTH    = 128,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1,
  localparam int KW = TDATA_WIDTH / 8,
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [CHANNEL_NUM*TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [CHANNEL_NUM*KW-1:0]       S_AXIS_TKEEP,
  input  logic [CHANNEL_NUM-1:0]          S_AXIS_TVALID,
  input  logic [CHANNEL_NUM-1:0]          S_AXIS_TLAST,
  output logic [CHANNEL_NUM-1:0]          S_AXIS_TREADY,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TVALID,
  output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
  output logic [KW-1:0]                   M_AXIS_TKEEP,
  output logic                            M_AXIS_TLAST,
  output logic [GW-1:0]                   GRANT_ID,
  output logic [31:0]                     FRAME_COUNT,
  output logic                            MERGER_ERROR
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic                   m_valid_q, m_valid_d;
  logic [TDATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KW-1:0]          m_keep_q, m_keep_d;
  logic                   m_last_q, m_last_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;
  logic [SW-1:0]          stall_q, stall_d;
  logic                   err_q, err_d;

  logic [GW-1:0]          pick;
  logic                   any_req;
  logic                   g_vld, g_last, out_free, s_hs;
  logic [TDATA_WIDTH-1:0] g_data;
  logic [KW-1:0]          g_keep;

  // Walk downward so the last hit is the nearest channel above the previous grant;
  // the previous grant itself comes last.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = grant_q;
    any_req = 1'b0;
    for (int i = CHANNEL_NUM; i >= 1; i--) begin
      idx = int'(grant_q) + i;
      if (idx >= CHANNEL_NUM) idx = idx - CHANNEL_NUM;
      if (S_AXIS_TVALID[idx]) begin
        pick    = GW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign g_vld    = S_AXIS_TVALID[grant_q];
  assign g_last   = S_AXIS_TLAST[grant_q];
  assign g_data   = S_AXIS_TDATA[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
  assign g_keep   = S_AXIS_TKEEP[int'(grant_q)*KW +: KW];
  assign out_free = !m_valid_q || M_AXIS_TREADY;
  assign s_hs     = (state_q == XFER) && g_vld && out_free;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = XFER;
      XFER:    if (s_hs && g_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    S_AXIS_TREADY = '0;
    if (state_q == XFER) S_AXIS_TREADY[grant_q] = out_free;
  end

  always_comb begin
    grant_d     = (state_q == IDLE && any_req) ? pick : grant_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    if (s_hs) begin
      m_valid_d = 1'b1;
      m_data_d  = g_data;
      m_keep_d  = g_keep;
      m_last_d  = g_last;
    end else if (M_AXIS_TREADY) begin
      m_valid_d = 1'b0;
    end
    frame_cnt_d = frame_cnt_q + 32'(m_valid_q && M_AXIS_TREADY && m_last_q);
    // Stall only accrues while the granted source idles mid-frame; it saturates at the limit.
    stall_d = stall_q;
    if (state_q != XFER || s_hs)                         stall_d = '0;
    else if (!g_vld && stall_q != SW'(TIMEOUT_CYCLES))   stall_d = stall_q + 1'b1;
    err_d = err_q || (stall_d == SW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      grant_q     <= GW'(CHANNEL_NUM - 1);
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= '0;
      stall_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TKEEP  = m_keep_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign GRANT_ID      = grant_q;
  assign FRAME_COUNT   = frame_cnt_q;
  assign MERGER_ERROR  = err_q;

endmodule
